pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, meaning: PC value loaded on reset.
REQ-002 Parameter WAIT_LIMIT, default 8, meaning: maximum cycles in WAIT before Fetch_err is flagged.
REQ-003 Port clk  input  1  meaning: single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  meaning: synchronous, active-high reset.
REQ-005 Port NPC  input  32  meaning: next-PC from the next-PC logic, sampled on Advance.
REQ-006 Port Advance  input  1  meaning: consumer accepts the current instruction; PC moves to NPC.
REQ-007 Port imem_req  output  1  meaning: instruction-memory read request.
REQ-008 Port imem_addr  output  32  meaning: read address; equals PC.
REQ-009 Port imem_ack  input  1  meaning: memory read data valid this cycle.
REQ-010 Port imem_rdata  input  32  meaning: instruction word, valid with imem_ack.
REQ-011 Port PC  output  32  meaning: address of the current instruction.
REQ-012 Port PC_add_4  output  32  meaning: PC + 4, modulo 2^32.
REQ-013 Port Instr  output  32  meaning: latched instruction word.
REQ-014 Port Instr_valid  output  1  meaning: Instr holds the word fetched from PC.
REQ-015 Port Beq_ext_imm  output  32  meaning: Instr[15:0] sign-extended to 32 bits.
REQ-016 Port Jump_ins_add  output  26  meaning: Instr[25:0].
REQ-017 Port Fetch_err  output  1  meaning: sticky error flag (timeout or misaligned NPC).

Function
REQ-018 The FSM SHALL have states REQ, WAIT, VALID, HALT.
REQ-019 REQ: imem_req=1, imem_addr=PC; imem_ack in the same cycle -> latch imem_rdata into Instr, go to VALID; else go to WAIT.
REQ-020 WAIT: imem_req stays 1, imem_addr stable; on imem_ack, latch Instr and go to VALID.
REQ-021 A WAIT counter SHALL count cycles in WAIT; reaching WAIT_LIMIT without ack sets Fetch_err and goes to HALT.
REQ-022 VALID: Instr_valid=1, imem_req=0; Instr held until Advance.
REQ-023 VALID with Advance=1: PC <= NPC, Instr_valid drops next cycle, go to REQ.
REQ-024 Advance outside VALID SHALL be ignored; PC unchanged.
REQ-025 imem_ack while imem_req=0 SHALL be ignored.
REQ-026 HALT: imem_req=0, Instr_valid=0, PC frozen; exit only by rst.
REQ-027 Fetch-to-valid latency: with imem_ack in the REQ cycle, Instr_valid is 1 the next cycle.
REQ-028 PC_add_4 = PC + 4, combinational; PC=32'hFFFF_FFFC gives 32'h0000_0000.
REQ-029 Beq_ext_imm and Jump_ins_add SHALL derive combinationally from Instr and are meaningful only when Instr_valid=1.

Reset
REQ-030 rst=1 at a clock edge: PC<=RESET_PC, Instr<=0, Instr_valid<=0, Fetch_err<=0, WAIT counter<=0, state<=REQ.
REQ-031 During and after reset: imem_req=0 while rst=1, then 1 in the first cycle after rst drops.
REQ-032 rst in WAIT SHALL abandon the outstanding request; a late imem_ack is ignored unless it arrives in the new REQ cycle.

Configuration
REQ-033 Macro PC_MISALIGN_CHECK_EN defined: on Advance in VALID with NPC[1:0]!=2'b00, Fetch_err<=1, go to HALT, PC unchanged.
REQ-034 Macro PC_MISALIGN_CHECK_EN undefined: PC <= {NPC[31:2],2'b00}; Fetch_err set only by timeout.

Verification
REQ-035 Reset, then imem_ack=1 in the first REQ cycle with rdata=32'h0800_0C05 -> PC=32'h0000_3000, next cycle Instr_valid=1, Jump_ins_add=26'h0000C05, PC_add_4=32'h0000_3004.
REQ-036 In VALID, rdata=32'h1000_FFFE, Advance with NPC=32'h0000_2FFC -> Beq_ext_imm=32'hFFFF_FFFE before Advance; after Advance, imem_addr=32'h0000_2FFC with imem_req=1.
REQ-037 Delay imem_ack 3 cycles -> imem_addr stable over 4 cycles, then Instr_valid=1; with WAIT_LIMIT=8 and no ack -> Fetch_err=1, state HALT, imem_req=0.
REQ-038 Hold Advance=0 in VALID for 5 cycles -> Instr and PC stable, imem_req=0; a spurious imem_ack changes nothing.
REQ-039 Assert rst in WAIT -> next cycle PC=RESET_PC, Instr_valid=0; ack during rst is ignored.
REQ-040 Advance with NPC=32'h0000_3006 -> with PC_MISALIGN_CHECK_EN: Fetch_err=1, PC=old value; without it: PC=32'h0000_3004.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage.
// Holds the program counter, requests the instruction at PC from instruction
// memory, latches the returned word and presents it until the consumer
// advances. A fetch that stays unanswered for WAIT_LIMIT cycles in WAIT raises
// the sticky Fetch_err and parks the stage in HALT until reset.
//
// Build option: define PC_MISALIGN_CHECK_EN to treat a misaligned NPC on
// Advance as a fatal error (Fetch_err, HALT, PC kept). Without it, the low two
// bits of NPC are dropped and the fetch continues at the word address.
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          WAIT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NPC,
  input  logic        Advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] PC_add_4,
  output logic [31:0] Instr,
  output logic        Instr_valid,
  output logic [31:0] Beq_ext_imm,
  output logic [25:0] Jump_ins_add,
  output logic        Fetch_err
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Counter wide enough to hold WAIT_LIMIT-1; the last WAIT cycle is the one
  // where the count equals WAIT_LAST.
  localparam int              CNT_W     = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t            r_state;
  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic              r_fetch_err;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic [31:0]       w_pc_next;
  logic              w_misaligned;

  // Word-aligned next PC: XOR with its own low bits clears them.
  assign w_misaligned = |NPC[1:0];
  assign w_pc_next    = NPC ^ {30'd0, NPC[1:0]};

  // Fetch FSM: PC, latched instruction, valid/error flags and wait counter.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          r_wait_cnt <= '0;
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_VALID;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_VALID;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_fetch_err <= 1'b1;
            r_state     <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_VALID: begin
          if (Advance) begin
`ifdef PC_MISALIGN_CHECK_EN
            if (w_misaligned) begin
              r_fetch_err   <= 1'b1;
              r_instr_valid <= 1'b0;
              r_state       <= S_HALT;
            end else begin
              r_pc          <= w_pc_next;
              r_instr_valid <= 1'b0;
              r_state       <= S_REQ;
            end
`else
            // Misalignment is not an error here; the low bits are dropped.
            r_pc          <= w_pc_next;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
`endif
          end
        end
        S_HALT: begin
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

`ifndef PC_MISALIGN_CHECK_EN
  // Misalignment only matters to the checked build; keep the term referenced.
  logic w_misaligned_unused;
  assign w_misaligned_unused = w_misaligned;
`endif

  // Request is decoded from state and masked by rst so it is low throughout
  // reset yet high in the very first cycle after rst drops.
  assign imem_req     = ~rst & ((r_state == S_REQ) | (r_state == S_WAIT));
  assign imem_addr    = r_pc;

  assign PC           = r_pc;
  assign PC_add_4     = r_pc + 32'd4;
  assign Instr        = r_instr;
  assign Instr_valid  = r_instr_valid;
  assign Fetch_err    = r_fetch_err;

  // Immediate fields decoded straight from the latched word.
  assign Beq_ext_imm  = {{16{r_instr[15]}}, r_instr[15:0]};
  assign Jump_ins_add = r_instr[25:0];

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: a table of single-cycle vectors followed by
// hand-written sequences for delayed ack, timeout, hold and reset-in-WAIT.
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] NPC;
  logic        Advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] PC_add_4;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] Beq_ext_imm;
  logic [25:0] Jump_ins_add;
  logic        Fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch #(
    .RESET_PC  (32'h0000_3000),
    .WAIT_LIMIT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .NPC         (NPC),
    .Advance     (Advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .PC          (PC),
    .PC_add_4    (PC_add_4),
    .Instr       (Instr),
    .Instr_valid (Instr_valid),
    .Beq_ext_imm (Beq_ext_imm),
    .Jump_ins_add(Jump_ins_add),
    .Fetch_err   (Fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        adv;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] rdata;
    logic        pre_req;   // imem_req in the cycle the inputs are applied
    logic        req;       // remaining fields: after the clock edge
    logic [31:0] pc;
    logic        valid;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input string n, input logic r, input logic a,
                              input logic [31:0] np, input logic ak,
                              input logic [31:0] rd, input logic pq,
                              input logic q, input logic [31:0] p,
                              input logic v, input logic [31:0] ins,
                              input logic e);
    vec_t t;
    t.name = n; t.rst = r; t.adv = a; t.npc = np; t.ack = ak; t.rdata = rd;
    t.pre_req = pq; t.req = q; t.pc = p; t.valid = v; t.instr = ins; t.err = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] np,
                       input logic ak, input logic [31:0] rd);
    rst = r; Advance = a; NPC = np; imem_ack = ak; imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] exp_beq;
    drive(v.rst, v.adv, v.npc, v.ack, v.rdata);
    #1;
    check({v.name, ".pre_req"}, {31'd0, imem_req}, {31'd0, v.pre_req});
    tick();
    check({v.name, ".req"},   {31'd0, imem_req},    {31'd0, v.req});
    check({v.name, ".pc"},    PC,                   v.pc);
    check({v.name, ".addr"},  imem_addr,            v.pc);
    check({v.name, ".pc4"},   PC_add_4,             v.pc + 32'd4);
    check({v.name, ".valid"}, {31'd0, Instr_valid}, {31'd0, v.valid});
    check({v.name, ".instr"}, Instr,                v.instr);
    check({v.name, ".err"},   {31'd0, Fetch_err},   {31'd0, v.err});
    if (v.valid) begin
      exp_beq = {{16{v.instr[15]}}, v.instr[15:0]};
      check({v.name, ".beq"}, Beq_ext_imm, exp_beq);
      check({v.name, ".jump"}, {6'd0, Jump_ins_add}, {6'd0, v.instr[25:0]});
    end
  endtask

  vec_t vecs[12];

  initial begin
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

    //                  name         rst adv npc           ack rdata          pre req pc            vld instr          err
    vecs[0]  = mk("reset0",       1, 0, 32'h0,         0, 32'h0,          0,  0, 32'h0000_3000, 0, 32'h0,          0);
    vecs[1]  = mk("reset_ack",    1, 0, 32'h0,         1, 32'hDEAD_BEEF,  0,  0, 32'h0000_3000, 0, 32'h0,          0);
    vecs[2]  = mk("fetch0",       0, 0, 32'h0,         1, 32'h0800_0C05,  1,  0, 32'h0000_3000, 1, 32'h0800_0C05,  0);
    vecs[3]  = mk("spurious_ack", 0, 0, 32'h0,         1, 32'hFFFF_FFFF,  0,  0, 32'h0000_3000, 1, 32'h0800_0C05,  0);
    vecs[4]  = mk("adv_3004",     0, 1, 32'h0000_3004, 0, 32'h0,          0,  1, 32'h0000_3004, 0, 32'h0800_0C05,  0);
    vecs[5]  = mk("fetch_beq",    0, 0, 32'h0,         1, 32'h1000_FFFE,  1,  0, 32'h0000_3004, 1, 32'h1000_FFFE,  0);
    vecs[6]  = mk("adv_2ffc",     0, 1, 32'h0000_2FFC, 0, 32'h0,          0,  1, 32'h0000_2FFC, 0, 32'h1000_FFFE,  0);
    vecs[7]  = mk("adv_in_req",   0, 1, 32'h0000_5000, 0, 32'h0,          1,  1, 32'h0000_2FFC, 0, 32'h1000_FFFE,  0);
    vecs[8]  = mk("ack_in_wait",  0, 0, 32'h0,         1, 32'h0000_1234,  1,  0, 32'h0000_2FFC, 1, 32'h0000_1234,  0);
    vecs[9]  = mk("adv_back",     0, 1, 32'h0000_3004, 0, 32'h0,          0,  1, 32'h0000_3004, 0, 32'h0000_1234,  0);
    vecs[10] = mk("fetch_neg",    0, 0, 32'h0,         1, 32'h2400_8000,  1,  0, 32'h0000_3004, 1, 32'h2400_8000,  0);
`ifdef PC_MISALIGN_CHECK_EN
    vecs[11] = mk("adv_misalign", 0, 1, 32'h0000_3006, 0, 32'h0,          0,  0, 32'h0000_3004, 0, 32'h2400_8000,  1);
`else
    vecs[11] = mk("adv_misalign", 0, 1, 32'h0000_3006, 0, 32'h0,          0,  1, 32'h0000_3004, 0, 32'h2400_8000,  0);
`endif

    for (int i = 0; i < 12; i++) apply(vecs[i]);

    // Delayed ack: request held stable for four cycles, ack in the fourth.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    check("dly.reset_pc", PC, 32'h0000_3000);
    check("dly.reset_err", {31'd0, Fetch_err}, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h8C0A_0004);
      #1;
      check($sformatf("dly.req%0d", i), {31'd0, imem_req}, 32'd1);
      check($sformatf("dly.addr%0d", i), imem_addr, 32'h0000_3000);
      tick();
    end
    check("dly.valid", {31'd0, Instr_valid}, 32'd1);
    check("dly.instr", Instr, 32'h8C0A_0004);

    // Wrap of PC_add_4, then timeout into HALT.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("wrap.pc", PC, 32'hFFFF_FFFC);
    check("wrap.pc4", PC_add_4, 32'h0000_0000);
    check("wrap.req", {31'd0, imem_req}, 32'd1);
    tick();                                   // REQ -> WAIT
    for (int i = 0; i < 7; i++) tick();       // WAIT cycles 2..8
    check("to.req_last_wait", {31'd0, imem_req}, 32'd1);
    check("to.err_last_wait", {31'd0, Fetch_err}, 32'd0);
    tick();
    check("to.err", {31'd0, Fetch_err}, 32'd1);
    check("to.req", {31'd0, imem_req}, 32'd0);
    check("to.valid", {31'd0, Instr_valid}, 32'd0);
    drive(1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_1234);
    for (int i = 0; i < 3; i++) tick();
    check("halt.pc", PC, 32'hFFFF_FFFC);
    check("halt.req", {31'd0, imem_req}, 32'd0);
    check("halt.valid", {31'd0, Instr_valid}, 32'd0);
    check("halt.err", {31'd0, Fetch_err}, 32'd1);
    check("halt.instr", Instr, 32'h8C0A_0004);

    // Reset clears the error; then hold VALID for five cycles.
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    check("hold.reset_err", {31'd0, Fetch_err}, 32'd0);
    check("hold.reset_pc", PC, 32'h0000_3000);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hABCD_1234);
    tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0000);
      else        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      check($sformatf("hold.instr%0d", i), Instr, 32'hABCD_1234);
      check($sformatf("hold.pc%0d", i), PC, 32'h0000_3000);
      check($sformatf("hold.req%0d", i), {31'd0, imem_req}, 32'd0);
      check($sformatf("hold.valid%0d", i), {31'd0, Instr_valid}, 32'd1);
    end

    // Reset while waiting: ack during rst is dropped, ack in new REQ is taken.
    drive(1'b0, 1'b1, 32'h0000_3008, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();                                   // now in WAIT
    check("rw.wait_req", {31'd0, imem_req}, 32'd1);
    check("rw.wait_addr", imem_addr, 32'h0000_3008);
    drive(1'b1, 1'b0, 32'd0, 1'b1, 32'h5555_5555);
    #1;
    check("rw.req_in_rst", {31'd0, imem_req}, 32'd0);
    tick();
    check("rw.pc", PC, 32'h0000_3000);
    check("rw.valid", {31'd0, Instr_valid}, 32'd0);
    check("rw.instr", Instr, 32'h0000_0000);
    drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h1111_0000);
    #1;
    check("rw.req_after", {31'd0, imem_req}, 32'd1);
    check("rw.addr_after", imem_addr, 32'h0000_3000);
    tick();
    check("rw.new_valid", {31'd0, Instr_valid}, 32'd1);
    check("rw.new_instr", Instr, 32'h1111_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
